alu_pipe: RTL
=============

# alu_pipe

Parametrised, two-stage pipelined ALU. It keeps the eight-operation opcode map of the existing combinational ALU, adds status flags, a running-accumulator operand mode and valid/ready handshakes on input and output. It sits between an operand/command source and a result consumer, and sustains one operation per clock under backpressure.

## Interface
- WIDTH, 32, operand and result width in bits; minimum 2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  command/operands present.
- in_ready  output  1  stage 1 can accept this cycle.
- op_code  input  3  operation select (map below).
- acc_sel  input  1  when 1, operand A is replaced by the accumulator.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result this cycle.
- y  output  WIDTH  result.
- flag_z  output  1  y == 0.
- flag_n  output  1  y[WIDTH-1].
- flag_c  output  1  carry out for add/inc; borrow (1 when unsigned A < subtrahend) for sub/dec.
- flag_v  output  1  signed overflow.

## Operation
- Opcode map:
  - 000 = A
  - 001 = A+B
  - 010 = A−B
  - 011 = A&B
  - 100 = A|B
  - 101 = A+1
  - 110 = A−1
  - 111 = B
- All 8 codes are defined. There is no Z/default output.
- Arithmetic is modulo 2^WIDTH. It is computed on WIDTH+1 bits to derive flag_c.
- flag_v rules:
  - add/inc: 1 when both operands have the same sign and the result sign differs.
  - sub/dec: 1 when the operands have different signs and the result sign differs from A.
- Opcodes 000, 011, 100 and 111 force flag_c = 0 and flag_v = 0.
- Stage 1 (S1) registers op_code, acc_sel, a, b and s1_valid on each input handshake (in_valid && in_ready).
- Stage 2 (S2) computes combinationally from S1 and registers y, flags and out_valid.
- The effective A is acc when S1.acc_sel = 1, otherwise S1.a.
- acc is a WIDTH-bit register. It loads the new result on the same edge S2 loads. acc therefore always holds the result of the most recent operation that entered S2, including results not yet consumed.
- acc chains back-to-back without bubbles. No flush or reload path exists other than reset.
- Advance conditions:
  - s2_adv = !out_valid || out_ready.
  - S2 loads when s2_adv: out_valid <= s1_valid; y/flags/acc update only if s1_valid.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv.
  - S1 loads the input when s1_adv: s1_valid <= in_valid.
- in_ready depends combinationally on out_ready (no skid buffer). This is accepted.
- Backpressure: while out_valid && !out_ready, y and all flags hold stable, acc holds, and S1 holds.
- Ordering is strictly FIFO. No operation is dropped or duplicated.

## Timing
- Reset (asynchronous assert) clears: s1_valid, out_valid, y, all flags, acc, and all S1 registers, all to 0.
- Output behaviour while and after reset:
  - in_ready reads 1 after reset.
  - Because in_ready = !s1_valid || s2_adv, it also reads 1 while reset is held.
  - All other outputs read 0 during reset.
- Latency: an input accepted at edge k gives out_valid at edge k+1, i.e. the result is visible in the cycle after the second edge.
- Throughput: 1 op/clock when out_ready is held high.
- Simultaneous consume and refill: S2 accepts a new result on the same edge the old one is consumed.
- Reset mid-operation discards all in-flight operations. The first post-reset op with acc_sel = 1 uses acc = 0.
- The input is ignored while in_ready = 0. The source must hold its values until accepted.

## Test plan
- Reset check: assert reset with in_valid = 1 → out_valid = 0, y = 0, all flags 0. After release, in_ready = 1.
- Add carry (WIDTH = 32): a = FFFFFFFF, b = 1, op 001 → after latency 2, y = 0, z = 1, c = 1, v = 0, n = 0.
- Sub overflow: a = 80000000, op 110 → y = 7FFFFFFF, v = 1, c = 0, n = 0. Also a = 3, b = 5, op 010 → y = FFFFFFFE, c = 1, n = 1.
- Accumulator chain, back-to-back with out_ready = 1:
  - op 111 with b = 10
  - then op 001 with acc_sel = 1, b = 5
  - then op 101 with acc_sel = 1
  - → y sequence 10, 15, 16 on consecutive cycles.
- Backpressure: stream 4 ops (A = 1, 2, 3, 4, op 000) while holding out_ready = 0 for 3 cycles.
  - in_ready drops after 2 accepts.
  - y holds at 1 while stalled.
  - On release the outputs are 1, 2, 3, 4 in order, with no loss.
- Reset mid-stream: assert reset with 2 ops in flight → out_valid goes 0 immediately and no stale result appears afterwards. A following acc_sel = 1, op 101 gives y = 1.

Source files
------------

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with status flags, a running accumulator operand and
// valid/ready handshakes. S1 registers the command; S2 computes and registers the result.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op_code,
    input  logic             acc_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);
    localparam int MSB = WIDTH - 1;

    typedef struct packed {
        logic [2:0]       op;
        logic             acc_sel;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } cmd_t;

    cmd_t             s1;
    logic [2:1]       vld_pipe;   // [1] = S1 holds a command, [2] = S2 holds a result
    logic [WIDTH-1:0] acc;
    logic             s1_adv, s2_adv;

    logic [WIDTH-1:0] eff_a, opnd, res;
    logic [WIDTH:0]   sum, dif;
    logic             res_c, res_v;

    assign s2_adv    = !vld_pipe[2] || out_ready;
    assign s1_adv    = !vld_pipe[1] || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = vld_pipe[2];

    // inc/dec share the add/sub datapath with a constant-one second operand
    always_comb begin
        eff_a = s1.acc_sel ? acc : s1.a;
        opnd  = (s1.op == 3'b101 || s1.op == 3'b110) ? WIDTH'(1) : s1.b;
        sum   = {1'b0, eff_a} + {1'b0, opnd};
        dif   = {1'b0, eff_a} - {1'b0, opnd};
        res   = eff_a;
        res_c = 1'b0;
        res_v = 1'b0;
        unique case (s1.op)
            3'b000: res = eff_a;
            3'b001, 3'b101: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (eff_a[MSB] == opnd[MSB]) && (sum[MSB] != eff_a[MSB]);
            end
            3'b010, 3'b110: begin
                res   = dif[WIDTH-1:0];
                res_c = dif[WIDTH];
                res_v = (eff_a[MSB] != opnd[MSB]) && (dif[MSB] != eff_a[MSB]);
            end
            3'b011: res = eff_a & s1.b;
            3'b100: res = eff_a | s1.b;
            3'b111: res = s1.b;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            s1       <= '0;
            acc      <= '0;
            y        <= '0;
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
            flag_c   <= 1'b0;
            flag_v   <= 1'b0;
        end else begin
            if (s1_adv) begin
                vld_pipe[1] <= in_valid;
                if (in_valid)
                    s1 <= '{op: op_code, acc_sel: acc_sel, a: a, b: b};
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    y      <= res;
                    acc    <= res;
                    flag_z <= (res == '0);
                    flag_n <= res[MSB];
                    flag_c <= res_c;
                    flag_v <= res_v;
                end
            end
        end
    end
endmodule
